// File: rtl/ws_sta_feeder_32_if.sv
// Handshake and array-facing bus of the weight-stationary systolic feeder.
// The master side drives weights and activations; the slave side is the feeder.
interface ws_sta_feeder_32_if #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
);
  logic [N*W-1:0] b_data;
  logic           b_valid;
  logic           b_ready;
  logic [N*W-1:0] a_data;
  logic           a_valid;
  logic           a_ready;
  logic           a_last;
  logic [N*W-1:0] io_inputB;
  logic [N-1:0]   io_propagateB;
  logic [N*W-1:0] io_inputA;
  logic           busy;
  logic           done;

  modport master (
    output b_data, b_valid, a_data, a_valid, a_last,
    input  b_ready, a_ready, io_inputB, io_propagateB, io_inputA, busy, done
  );

  modport slave (
    input  b_data, b_valid, a_data, a_valid, a_last,
    output b_ready, a_ready, io_inputB, io_propagateB, io_inputA, busy, done
  );
endinterface

// File: rtl/ws_sta_feeder_32.sv
// Weight-stationary systolic array feeder: shifts N weight rows into the columns,
// then streams activation vectors through a per-row skew pipeline and drains it.
module ws_sta_feeder_32 #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input logic               clock,
  input logic               reset,
  ws_sta_feeder_32_if.slave bus
);
  localparam int unsigned   CW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastIdx    = CW'(N - 1);
  localparam logic [CW-1:0] PreLastIdx = CW'(N - 2);

  typedef enum logic [1:0] {Idle, LoadB, StreamA, Drain} stateT;

  stateT          stateQ;
  logic [CW-1:0]  rowCntQ;
  logic [CW-1:0]  drainCntQ;
  logic [N*W-1:0] inputBQ;
  logic [N-1:0]   propagateBQ;
  logic           doneQ;

  logic           bReady;
  logic           aReady;
  logic           bAccept;
  logic           aAccept;
  logic [N*W-1:0] injVec;
  logic [N*W-1:0] inputA;

  assign bReady  = (stateQ == LoadB);
  assign aReady  = (stateQ == StreamA);
  assign bAccept = bus.b_valid & bReady;
  assign aAccept = bus.a_valid & aReady;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ      <= Idle;
      rowCntQ     <= '0;
      drainCntQ   <= '0;
      inputBQ     <= '0;
      propagateBQ <= '0;
      doneQ       <= 1'b0;
    end else begin
      propagateBQ <= '0;
      doneQ       <= 1'b0;
      // A whole row is presented together with its shift strobe, never partially.
      if (bAccept) begin
        inputBQ     <= bus.b_data;
        propagateBQ <= '1;
      end
      unique case (stateQ)
        Idle: begin
          if (bus.b_valid) stateQ <= LoadB;
        end
        LoadB: begin
          if (bAccept) begin
            if (rowCntQ == LastIdx) begin
              rowCntQ <= '0;
              stateQ  <= StreamA;
            end else begin
              rowCntQ <= rowCntQ + CW'(1);
            end
          end
        end
        StreamA: begin
          if (aAccept && bus.a_last) begin
            stateQ    <= Drain;
            drainCntQ <= '0;
            doneQ     <= (N == 1);
          end
        end
        Drain: begin
          // done is raised one edge early so it lands on the final drain cycle,
          // the same cycle lane N-1 presents the tile's last vector.
          if (drainCntQ == LastIdx) begin
            drainCntQ <= '0;
            stateQ    <= Idle;
          end else begin
            drainCntQ <= drainCntQ + CW'(1);
            doneQ     <= (drainCntQ == PreLastIdx);
          end
        end
        default: stateQ <= Idle;
      endcase
    end
  end

  assign injVec = aAccept ? bus.a_data : '0;

  // Lane i delays its slice by i+1 registers; the pipe runs every cycle in every state.
  for (genvar i = 0; i < N; i++) begin : gLane
    logic [W-1:0] sr [0:i];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else begin
        sr[0] <= injVec[i*W +: W];
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end

    assign inputA[i*W +: W] = sr[i];
  end

  assign bus.b_ready       = bReady;
  assign bus.a_ready       = aReady;
  assign bus.io_inputB     = inputBQ;
  assign bus.io_propagateB = propagateBQ;
  assign bus.io_inputA     = inputA;
  assign bus.busy          = (stateQ != Idle);
  assign bus.done          = doneQ;
endmodule

// File: tb/tb_ws_sta_feeder_32.sv
// Directed bench for ws_sta_feeder_32: weight load, skewed streaming, drain/done,
// stalled loads, ignored handshakes and asynchronous reset mid-tile.
module tb_ws_sta_feeder_32;
  localparam int unsigned N  = 32;
  localparam int unsigned W  = 8;
  localparam int unsigned BW = N * W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nFail   = 0;
  logic [BW-1:0] expV;

  ws_sta_feeder_32_if #(.N(N), .W(W)) bus ();

  ws_sta_feeder_32 #(.N(N), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [BW-1:0] fill(input logic [W-1:0] v);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  task automatic chkV(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkB(input string tag, input logic obs, input logic exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    bus.b_valid = 1'b0;
    bus.b_data  = '0;
    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    bus.a_last  = 1'b0;

    // Asynchronous reset, no clock edge yet
    #3 reset = 1'b0;
    #1;
    chkB("rst_busy", bus.busy, 1'b0);
    chkB("rst_done", bus.done, 1'b0);
    chkB("rst_b_ready", bus.b_ready, 1'b0);
    chkB("rst_a_ready", bus.a_ready, 1'b0);
    chkV("rst_inputA", bus.io_inputA, '0);
    chkV("rst_inputB", bus.io_inputB, '0);
    chkB("rst_propB_any", |bus.io_propagateB, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // a_valid in IDLE is ignored
    bus.a_valid = 1'b1;
    bus.a_data  = fill(8'h77);
    bus.a_last  = 1'b1;
    @(negedge clock);
    chkB("idle_busy", bus.busy, 1'b0);
    chkB("idle_a_ready", bus.a_ready, 1'b0);
    chkV("idle_inputA", bus.io_inputA, '0);

    // Load 32 rows with b_valid held high; a_valid stays high and must be ignored
    bus.b_valid = 1'b1;
    bus.b_data  = fill(8'd1);
    @(negedge clock);
    chkB("load_b_ready", bus.b_ready, 1'b1);
    chkB("load_busy", bus.busy, 1'b1);
    chkB("load_propB_first", |bus.io_propagateB, 1'b0);
    for (int r = 1; r <= 32; r++) begin
      @(negedge clock);
      chkV("load_inputB", bus.io_inputB, fill(W'(r)));
      chkB("load_propB_ones", &bus.io_propagateB, 1'b1);
      chkV("load_inputA_quiet", bus.io_inputA, '0);
      if (r < 32) bus.b_data = fill(W'(r + 1));
    end
    chkB("stream_entry_a_ready", bus.a_ready, 1'b1);
    chkB("stream_entry_b_ready", bus.b_ready, 1'b0);
    bus.a_valid = 1'b0;
    bus.a_last  = 1'b0;

    // b_valid in STREAM_A is ignored
    @(negedge clock);
    chkB("stream_propB_idle", |bus.io_propagateB, 1'b0);
    chkV("stream_inputB_hold", bus.io_inputB, fill(8'd32));
    chkB("stream_a_ready", bus.a_ready, 1'b1);
    bus.b_valid = 1'b0;

    // Single-vector tile, lane i = i+1
    for (int i = 0; i < N; i++) bus.a_data[i*W +: W] = W'(i + 1);
    bus.a_valid = 1'b1;
    bus.a_last  = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) expV[i*W +: W] = (k == i + 1) ? W'(i + 1) : '0;
      chkV("one_inputA", bus.io_inputA, expV);
      chkB("one_done", bus.done, k == 32);
      chkB("one_busy", bus.busy, k <= 32);
      if (k == 1) begin
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
      end
    end

    // Load with b_valid toggling every other cycle
    bus.b_valid = 1'b1;
    bus.b_data  = fill(8'd0);
    for (int c = 1; c <= 65; c++) begin
      @(negedge clock);
      if (c >= 2) begin
        chkB("gap_propB_ones", &bus.io_propagateB, c % 2 == 0);
        chkB("gap_propB_any", |bus.io_propagateB, c % 2 == 0);
        chkV("gap_inputB", bus.io_inputB, fill(W'((c % 2 == 0) ? c - 1 : c - 2)));
        chkB("gap_a_ready", bus.a_ready, c >= 64);
      end
      if (c <= 64) begin
        bus.b_valid = (c % 2 == 1);
        bus.b_data  = fill(W'(c));
      end else begin
        bus.b_valid = 1'b0;
      end
    end

    // 20 back-to-back vectors, vector v lanes = 255-v, last on v=19
    chkB("burst_a_ready", bus.a_ready, 1'b1);
    for (int k = 0; k <= 53; k++) begin
      if (k > 0) begin
        @(negedge clock);
        for (int i = 0; i < N; i++)
          expV[i*W +: W] = (k >= i + 1 && k <= i + 20) ? W'(255 - (k - i - 1)) : '0;
        chkV("burst_inputA", bus.io_inputA, expV);
        chkB("burst_done", bus.done, k == 51);
        chkB("burst_busy", bus.busy, k <= 51);
      end
      if (k < 20) begin
        bus.a_valid = 1'b1;
        bus.a_data  = fill(W'(255 - k));
        bus.a_last  = (k == 19);
      end else begin
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
      end
    end

    // Reset in the middle of a stream with data in flight
    bus.b_valid = 1'b1;
    bus.b_data  = fill(8'h3c);
    repeat (33) @(negedge clock);
    bus.b_valid = 1'b0;
    chkB("rst2_a_ready", bus.a_ready, 1'b1);
    bus.a_valid = 1'b1;
    bus.a_data  = fill(8'ha5);
    bus.a_last  = 1'b0;
    repeat (3) @(negedge clock);
    expV = '0;
    for (int i = 0; i < 3; i++) expV[i*W +: W] = 8'ha5;
    chkV("rst2_inflight", bus.io_inputA, expV);
    #2 reset = 1'b0;
    #1;
    chkV("rst2_inputA", bus.io_inputA, '0);
    chkV("rst2_inputB", bus.io_inputB, '0);
    chkB("rst2_propB", |bus.io_propagateB, 1'b0);
    chkB("rst2_busy", bus.busy, 1'b0);
    chkB("rst2_a_ready", bus.a_ready, 1'b0);
    chkB("rst2_done", bus.done, 1'b0);
    bus.a_last = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chkB("post_rst_busy", bus.busy, 1'b0);
      chkB("post_rst_a_ready", bus.a_ready, 1'b0);
      chkV("post_rst_inputA", bus.io_inputA, '0);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1;
    @(negedge clock);
    chkB("restart_busy", bus.busy, 1'b1);
    chkB("restart_b_ready", bus.b_ready, 1'b1);
    chkV("restart_inputA", bus.io_inputA, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
